// File: rtl/daq_event_packer.sv
// rtl/daq_event_packer.sv - frames 32-bit stream packets into AMC13 64-bit DAQ events
module daq_event_packer #(
    parameter logic [11:0] SOURCE_ID         = 12'h000,
    parameter logic [3:0]  EVT_TYPE          = 4'h1,
    parameter int          MAX_PAYLOAD_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        daq_valid,
    output logic        daq_header,
    output logic        daq_trailer,
    output logic [63:0] daq_data,
    input  logic        daq_almost_full,
    input  logic        daq_ready,
    output logic [23:0] event_count,
    output logic [15:0] trunc_count,
    output logic        busy
);

    localparam int            CW       = $clog2(MAX_PAYLOAD_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2,
        TRAILER = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          link_ok;
    logic          tready_c;
    logic          accept;
    logic          emit_hdr;
    logic          emit_trl;
    logic          payload_accept;
    logic          at_last_slot;
    logic [CW-1:0] word_cnt;
    logic [31:0]   hold_lo;
    logic          trunc_flag;
    logic [23:0]   lv1_id;
    logic [23:0]   trl_len;
    logic [63:0]   header_word;
    logic [63:0]   trailer_word;

    assign link_ok      = daq_ready & ~daq_almost_full;
    assign at_last_slot = (word_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_axis_tvalid && link_ok) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        state_nxt = TRAILER;
                    end else if (at_last_slot) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) begin
                    state_nxt = TRAILER;
                end
            end
            TRAILER: begin
                if (link_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Drain keeps tready high even when the link is stalled: nothing is emitted there.
    always_comb begin
        tready_c = 1'b0;
        emit_hdr = 1'b0;
        emit_trl = 1'b0;
        case (state)
            IDLE:    emit_hdr = s_axis_tvalid & link_ok;
            PAYLOAD: tready_c = link_ok;
            DRAIN:   tready_c = 1'b1;
            TRAILER: emit_trl = link_ok;
            default: ;
        endcase
    end

    assign s_axis_tready  = tready_c;
    assign accept         = s_axis_tvalid & tready_c;
    assign payload_accept = accept & (state == PAYLOAD);
    assign busy           = (state != IDLE);

    // word_cnt is capped at MAX_PAYLOAD_WORDS because drained words are not counted.
    assign trl_len      = 24'd2 + ((24'(word_cnt) + 24'd1) >> 1);
    assign header_word  = {4'h5, EVT_TYPE, lv1_id, 12'h000, SOURCE_ID, 8'h00};
    assign trailer_word = {4'hA, 4'h0, trl_len, 16'h0000, 7'h00, trunc_flag, lv1_id[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            daq_valid   <= 1'b0;
            daq_header  <= 1'b0;
            daq_trailer <= 1'b0;
            daq_data    <= 64'h0;
            event_count <= 24'h0;
            trunc_count <= 16'h0;
            lv1_id      <= 24'h1;
            word_cnt    <= '0;
            hold_lo     <= 32'h0;
            trunc_flag  <= 1'b0;
        end else begin
            daq_valid   <= 1'b0;
            daq_header  <= 1'b0;
            daq_trailer <= 1'b0;

            if (emit_hdr) begin
                daq_valid  <= 1'b1;
                daq_header <= 1'b1;
                daq_data   <= header_word;
                word_cnt   <= '0;
                trunc_flag <= 1'b0;
            end

            if (payload_accept) begin
                word_cnt <= word_cnt + 1'b1;
                if (!word_cnt[0]) begin
                    if (s_axis_tlast) begin
                        daq_valid <= 1'b1;
                        daq_data  <= {32'h0, s_axis_tdata};
                    end else begin
                        hold_lo <= s_axis_tdata;
                    end
                end else begin
                    daq_valid <= 1'b1;
                    daq_data  <= {s_axis_tdata, hold_lo};
                end
                if (!s_axis_tlast && at_last_slot) begin
                    trunc_flag <= 1'b1;
                end
            end

            if (emit_trl) begin
                daq_valid   <= 1'b1;
                daq_trailer <= 1'b1;
                daq_data    <= trailer_word;
                event_count <= lv1_id;
                lv1_id      <= lv1_id + 24'h1;
                if (trunc_flag && (trunc_count != 16'hFFFF)) begin
                    trunc_count <= trunc_count + 16'h1;
                end
            end
        end
    end

endmodule

// File: tb/tb_daq_event_packer.sv
// tb/tb_daq_event_packer.sv - randomized scoreboard bench for daq_event_packer
module tb_daq_event_packer;

    localparam int          MAXW = 8;
    localparam logic [11:0] SRC  = 12'h0AB;
    localparam logic [3:0]  ETYP = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        daq_valid;
    logic        daq_header;
    logic        daq_trailer;
    logic [63:0] daq_data;
    logic        daq_almost_full;
    logic        daq_ready;
    logic [23:0] event_count;
    logic [15:0] trunc_count;
    logic        busy;

    daq_event_packer #(
        .SOURCE_ID        (SRC),
        .EVT_TYPE         (ETYP),
        .MAX_PAYLOAD_WORDS(MAXW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .daq_valid      (daq_valid),
        .daq_header     (daq_header),
        .daq_trailer    (daq_trailer),
        .daq_data       (daq_data),
        .daq_almost_full(daq_almost_full),
        .daq_ready      (daq_ready),
        .event_count    (event_count),
        .trunc_count    (trunc_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hdr;
        logic        trl;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] m_lv1    = 24'h1;
    logic [23:0] m_evcnt  = 24'h0;
    logic [15:0] m_trunc  = 16'h0;
    logic        prev_link_ok = 1'b1;
    bit          af_rand  = 1'b0;
    logic [31:0] wbuf[64];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected handshake at %0t", name, $time);
    endtask

    // Reference model: an event is header, ceil(min(n,MAX)/2) packed pairs, trailer.
    task automatic push_header();
        exp_t e;
        e.hdr  = 1'b1;
        e.trl  = 1'b0;
        e.data = {4'h5, ETYP, m_lv1, 12'h000, SRC, 8'h00};
        exp_q.push_back(e);
    endtask

    task automatic model_event(input int n);
        exp_t        e;
        int          acc;
        logic [23:0] len;
        logic        tr;
        push_header();
        acc = (n > MAXW) ? MAXW : n;
        for (int k = 0; k < acc; k += 2) begin
            e.hdr  = 1'b0;
            e.trl  = 1'b0;
            e.data = {((k + 1 < acc) ? wbuf[k+1] : 32'h0), wbuf[k]};
            exp_q.push_back(e);
        end
        len    = 24'(2 + (acc + 1) / 2);
        tr     = (n > MAXW);
        e.hdr  = 1'b0;
        e.trl  = 1'b1;
        e.data = {4'hA, 4'h0, len, 16'h0, 7'h0, tr, m_lv1[7:0]};
        exp_q.push_back(e);
        m_evcnt = m_lv1;
        m_lv1   = m_lv1 + 24'h1;
        if (tr && m_trunc != 16'hFFFF) m_trunc = m_trunc + 16'h1;
    endtask

    always @(posedge clk) prev_link_ok <= daq_ready & ~daq_almost_full;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && daq_valid) begin
            check64("valid_after_link_down", {63'h0, prev_link_ok}, 64'h1);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_daq_word");
            end else begin
                e = exp_q.pop_front();
                check64("daq_data", daq_data, e.data);
                check64("daq_header", {63'h0, daq_header}, {63'h0, e.hdr});
                check64("daq_trailer", {63'h0, daq_trailer}, {63'h0, e.trl});
            end
        end else if (rst_n && (daq_header || daq_trailer)) begin
            fail_now("flag_without_valid");
        end
    end

    task automatic check_tready(input int idx);
        logic lok;
        lok = daq_ready & ~daq_almost_full;
        if (!lok || idx >= MAXW)
            check64("tready", {63'h0, s_axis_tready}, {63'h0, (idx >= MAXW)});
    endtask

    task automatic offer(input logic [31:0] d, input bit last, input int idx, input bit gaps);
        int cyc = 0;
        bit hs  = 1'b0;
        while (!hs && cyc < 500) begin
            @(negedge clk);
            daq_ready       = 1'b1;
            daq_almost_full = af_rand ? ($urandom_range(0, 4) == 0) : 1'b0;
            s_axis_tvalid   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata    = d;
            s_axis_tlast    = last;
            #1;
            check_tready(idx);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            cyc++;
        end
        if (!hs) fail_now("offer_timeout");
    endtask

    task automatic send_event(input int n, input bit pattern, input bit gaps,
                              input int stall_idx, input bit stall_ready);
        for (int i = 0; i < n; i++)
            wbuf[i] = pattern ? 32'(32'h11111111 * (i + 1)) : $urandom;
        model_event(n);
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (stall_ready) daq_ready = 1'b0;
                    else daq_almost_full = 1'b1;
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = wbuf[i];
                    s_axis_tlast  = (i == n - 1);
                    #1;
                    check64("stall_tready", {63'h0, s_axis_tready}, 64'h0);
                    check64("stall_busy", {63'h0, busy}, {63'h0, (i != 0)});
                    @(posedge clk);
                end
            end
            offer(wbuf[i], (i == n - 1), i, gaps);
        end
        @(negedge clk);
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        daq_almost_full = 1'b0;
        daq_ready       = 1'b1;
    endtask

    task automatic wait_idle();
        int c = 0;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while ((busy || exp_q.size() != 0) && c < 300);
        if (c >= 300) fail_now("event_completion_timeout");
        check64("event_count", {40'h0, event_count}, {40'h0, m_evcnt});
        check64("trunc_count", {48'h0, trunc_count}, {48'h0, m_trunc});
    endtask

    task automatic check_outputs_zero(input string tag);
        check64({tag, "_valid"}, {61'h0, daq_valid, daq_header, daq_trailer}, 64'h0);
        check64({tag, "_data"}, daq_data, 64'h0);
        check64({tag, "_tready"}, {63'h0, s_axis_tready}, 64'h0);
        check64({tag, "_event_count"}, {40'h0, event_count}, 64'h0);
        check64({tag, "_trunc_count"}, {48'h0, trunc_count}, 64'h0);
        check64({tag, "_busy"}, {63'h0, busy}, 64'h0);
    endtask

    initial begin
        rst_n           = 1'b0;
        s_axis_tvalid   = 1'b0;
        s_axis_tdata    = 32'h0;
        s_axis_tlast    = 1'b0;
        daq_almost_full = 1'b0;
        daq_ready       = 1'b1;
        #2;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send_event(4, 1'b1, 1'b0, -1, 1'b0);
        wait_idle();
        send_event(3, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();
        send_event(1, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();

        send_event(6, 1'b0, 1'b0, 2, 1'b0);
        wait_idle();
        send_event(4, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();

        send_event(13, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();
        send_event(MAXW, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();

        af_rand = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send_event($urandom_range(1, 12), 1'b0, 1'b1, -1, 1'b0);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        af_rand = 1'b0;

        @(negedge clk);
        force dut.lv1_id = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.lv1_id;
        m_lv1 = 24'hFFFFFF;
        for (int k = 0; k < 3; k++) send_event(2 + k, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();

        push_header();
        offer(32'hCAFE0000, 1'b0, 0, 1'b0);
        offer(32'hCAFE0001, 1'b0, 1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check64("midreset_pending", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        m_lv1   = 24'h1;
        m_evcnt = 24'h0;
        m_trunc = 16'h0;
        send_event(5, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();

        repeat (5) @(negedge clk);
        check64("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish at %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
